spi_register_bridge: RTL and testbench
======================================

Name: spi_register_bridge

Overview:
- SPI peripheral that turns serial frames from the host MCU into the parallel register-write strobes consumed by the synth top level (register number, 24-bit value, write enable).
- Sits between the FPGA SPI pins and the synth register interface; it is the initiator side of that interface.
- All logic runs in the i_Clock domain; SPI pins are oversampled.

Parameters:
- FRAME_BITS, 40, bits per frame: 4 command + 12 register number + 24 value.
- SYNC_STAGES, 2, synchronizer flops on each SPI input (minimum 2).

Ports:
- i_Clock  input  1  system clock
- i_Reset  input  1  synchronous, active-high reset
- i_SPI_SCK  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0); frequency at most i_Clock/8
- i_SPI_CS_N  input  1  chip select, active low
- i_SPI_MOSI  input  1  serial data in, MSB first
- o_SPI_MISO  output  1  serial data out
- o_RegisterNumber  output  12  register number to synth
- o_RegisterValue  output  24  register value to synth
- o_RegisterWriteEnable  output  1  one-cycle write strobe
- o_FrameError  output  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset, clock: i_Reset is synchronous and active-high; the clock is i_Clock.
- Reset values: all outputs 0; FSM in WAIT_IDLE; bit counter 0; shift register 0.
- Synchronization: SCK, CS_N and MOSI each pass through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with one further history flop.
  - SCK rise: sample MOSI.
  - SCK fall: update MISO.
- Frame layout, MSB first:
  - bits [39:36] command: 4'h1 = WRITE, 4'h2 = READ (optional feature); others invalid.
  - bits [35:24] register number.
  - bits [23:0] value.
- FSM states:
  - WAIT_IDLE: waits for synced CS_N high, then goes to IDLE. This is the reset state, so a frame already in progress at reset is ignored.
  - IDLE: synced CS_N falling edge → SHIFT; counter cleared, shift register cleared.
  - SHIFT: each SCK rising edge shifts MOSI into shift-register bit 0; the counter increments and saturates at 63. A synced CS_N rising edge → CHECK.
  - CHECK (one cycle):
    - count == 40 and command == WRITE: load o_RegisterNumber/o_RegisterValue from the shift register; assert o_RegisterWriteEnable on the next cycle.
    - count == 40 and command == READ with the optional feature enabled: no strobe, no error.
    - Any other case, including count ≠ 40: pulse o_FrameError for one cycle; no write.
    - Then → IDLE.
- Latency: o_RegisterWriteEnable is high for exactly one cycle. It asserts on the 4th i_Clock posedge after the first posedge that samples i_SPI_CS_N high (with SYNC_STAGES = 2).
- o_RegisterNumber/o_RegisterValue hold their last written values between strobes. They are updated in the same cycle the strobe asserts.
- SCK edges while CS_N is high are ignored.
- A CS_N falling edge during CHECK is not possible, because CS_N high time must be ≥ 4 i_Clock cycles (host requirement). Glitches shorter than this are not supported.
- Reset asserted mid-frame: no strobe is emitted, the partial frame is discarded, and the FSM goes to WAIT_IDLE.
- Without the optional feature, o_SPI_MISO is constant 0.

Optional Feature:
- Macro: SPI_REGISTER_READBACK_EN.
- When defined, the block adds two ports:
  - o_RegisterReadEnable  output  1
  - i_RegisterReadValue  input  24
- READ frame sequence:
  - On the 16th sampled bit, o_RegisterNumber loads bits [11:0] of the shift register.
  - o_RegisterReadEnable pulses for one cycle.
  - i_RegisterReadValue is captured the next cycle into a 24-bit TX register.
  - o_SPI_MISO drives TX bit 23 and shifts left on each SCK falling edge from bit 16 to bit 39 inclusive.
  - o_SPI_MISO is 0 outside the data phase.
- The MOSI value bits of a READ frame are ignored.
- When the macro is undefined, command 4'h2 is invalid and produces o_FrameError.

Test Plan:
- WRITE 0x1_045_ABCDEF (40 bits, SCK = i_Clock/8), then CS_N high → o_RegisterNumber = 12'h045, o_RegisterValue = 24'hABCDEF, o_RegisterWriteEnable high exactly 1 cycle at the specified latency; o_FrameError stays 0.
- WRITE frame truncated to 39 bits → no write strobe, o_FrameError pulses once, outputs keep their previous values. A frame of 41 bits gives the same response.
- Command 4'h7 with 40 bits → o_FrameError pulses once, no strobe. A following valid WRITE 0x1_0C5_000001 → strobe with 12'h0C5 / 24'h000001.
- i_Reset asserted after bit 20 of a WRITE, released with CS_N still low, then CS_N high → no strobe, no error. A next full frame is accepted normally.
- (SPI_REGISTER_READBACK_EN) READ 0x2_046_000000 with i_RegisterReadValue = 24'h5A5A5A → one o_RegisterReadEnable pulse with o_RegisterNumber = 12'h046; MISO bits 16–39 = 0x5A5A5A; no write strobe.

Source files
------------

// File: rtl/spi_register_bridge.sv
// rtl/spi_register_bridge.sv - SPI frame receiver driving synth register-write strobes
// Optional readback path: define SPI_REGISTER_READBACK_EN.
// SYNC_STAGES must be at least 2.
module spi_register_bridge #(
  parameter int FRAME_BITS  = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SPI_SCK,
  input  logic        i_SPI_CS_N,
  input  logic        i_SPI_MOSI,
  output logic        o_SPI_MISO,
  output logic [11:0] o_RegisterNumber,
  output logic [23:0] o_RegisterValue,
  output logic        o_RegisterWriteEnable,
  output logic        o_FrameError
`ifdef SPI_REGISTER_READBACK_EN
  ,
  output logic        o_RegisterReadEnable,
  input  logic [23:0] i_RegisterReadValue
`endif
);

  localparam logic [3:0] CMD_WRITE   = 4'h1;
  localparam logic [3:0] CMD_READ    = 4'h2;
  localparam logic [5:0] FRAME_COUNT = 6'(FRAME_BITS);
  localparam logic [5:0] COUNT_MAX   = 6'd63;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_hist;
  logic                   cs_hist;

  logic sck_q;
  logic cs_q;
  logic mosi_q;
  logic sck_rise;
  logic cs_rise;
  logic cs_fall;

  state_t                 state;
  logic [5:0]             bit_count;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic                   write_pending;
  logic [3:0]             command;
  logic                   read_allowed;

  assign sck_q    = sck_sync[SYNC_STAGES-1];
  assign cs_q     = cs_sync[SYNC_STAGES-1];
  assign mosi_q   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_q & ~sck_hist;
  assign cs_rise  = cs_q & ~cs_hist;
  assign cs_fall  = ~cs_q & cs_hist;
  assign command  = shift_reg[FRAME_BITS-1 -: 4];

  // Sync chains reset to 0 so a frame in progress at reset never looks like idle CS_N.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_hist  <= 1'b0;
      cs_hist   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_SPI_SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
      sck_hist  <= sck_q;
      cs_hist   <= cs_q;
    end
  end

`ifdef SPI_REGISTER_READBACK_EN
  logic        sck_fall;
  logic        read_active;
  logic        read_capture;
  logic [23:0] tx_reg;
  logic        miso_reg;

  assign sck_fall     = ~sck_q & sck_hist;
  assign read_allowed = (command == CMD_READ);
  assign o_SPI_MISO   = miso_reg;
`else
  assign read_allowed = 1'b0;
  assign o_SPI_MISO   = 1'b0;
`endif

  // Frame FSM: collect bits while CS_N is low, validate on CS_N rise, emit registered strobes.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state                 <= WAIT_IDLE;
      bit_count             <= '0;
      shift_reg             <= '0;
      write_pending         <= 1'b0;
      o_RegisterNumber      <= '0;
      o_RegisterValue       <= '0;
      o_RegisterWriteEnable <= 1'b0;
      o_FrameError          <= 1'b0;
`ifdef SPI_REGISTER_READBACK_EN
      o_RegisterReadEnable  <= 1'b0;
      read_active           <= 1'b0;
      read_capture          <= 1'b0;
      tx_reg                <= '0;
      miso_reg              <= 1'b0;
`endif
    end else begin
      o_RegisterWriteEnable <= 1'b0;
      o_FrameError          <= 1'b0;
      write_pending         <= 1'b0;

      // Outputs and strobe change together, one cycle after the frame was validated.
      if (write_pending) begin
        o_RegisterWriteEnable <= 1'b1;
        o_RegisterNumber      <= shift_reg[FRAME_BITS-5 -: 12];
        o_RegisterValue       <= shift_reg[23:0];
      end

`ifdef SPI_REGISTER_READBACK_EN
      o_RegisterReadEnable <= 1'b0;
      read_capture         <= 1'b0;
      if (read_capture) begin
        tx_reg <= i_RegisterReadValue;
      end
`endif

      case (state)
        WAIT_IDLE: begin
          if (cs_q) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            bit_count <= '0;
            shift_reg <= '0;
`ifdef SPI_REGISTER_READBACK_EN
            read_active <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (sck_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_q};
            if (bit_count != COUNT_MAX) begin
              bit_count <= bit_count + 6'd1;
            end
`ifdef SPI_REGISTER_READBACK_EN
            // Sixteenth bit completes command + register number of a READ.
            if (bit_count == 6'd15 && shift_reg[14:11] == CMD_READ) begin
              o_RegisterNumber     <= {shift_reg[10:0], mosi_q};
              o_RegisterReadEnable <= 1'b1;
              read_capture         <= 1'b1;
              read_active          <= 1'b1;
            end
`endif
          end
`ifdef SPI_REGISTER_READBACK_EN
          // Present the next read-data bit ahead of the host's sampling edge.
          if (sck_fall) begin
            if (read_active && bit_count >= 6'd16 && bit_count <= 6'd39) begin
              miso_reg <= tx_reg[23];
              tx_reg   <= {tx_reg[22:0], 1'b0};
            end else begin
              miso_reg <= 1'b0;
            end
          end
`endif
          if (cs_rise) begin
            state <= CHECK;
          end
        end

        CHECK: begin
          if (bit_count == FRAME_COUNT && command == CMD_WRITE) begin
            write_pending <= 1'b1;
          end else if (!(bit_count == FRAME_COUNT && read_allowed)) begin
            o_FrameError <= 1'b1;
          end
`ifdef SPI_REGISTER_READBACK_EN
          miso_reg    <= 1'b0;
          read_active <= 1'b0;
`endif
          state <= IDLE;
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_register_bridge.sv
// tb/tb_spi_register_bridge.sv - randomized self-checking bench for spi_register_bridge
`timescale 1ns/1ps
module tb_spi_register_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [11:0] reg_num;
  logic [23:0] reg_val;
  logic        reg_we;
  logic        frame_err;
  logic [23:0] rd_value = 24'h5A5A5A;
`ifdef SPI_REGISTER_READBACK_EN
  logic        reg_re;
`endif

  spi_register_bridge dut (
    .i_Clock               (clk),
    .i_Reset               (rst),
    .i_SPI_SCK             (sck),
    .i_SPI_CS_N            (cs_n),
    .i_SPI_MOSI            (mosi),
    .o_SPI_MISO            (miso),
    .o_RegisterNumber      (reg_num),
    .o_RegisterValue       (reg_val),
    .o_RegisterWriteEnable (reg_we),
    .o_FrameError          (frame_err)
`ifdef SPI_REGISTER_READBACK_EN
    ,
    .o_RegisterReadEnable  (reg_re),
    .i_RegisterReadValue   (rd_value)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int we_cnt = 0;
  int err_cnt = 0;
  int re_cnt = 0;
  int we_cyc = 0;
  int cs_cyc = 0;
  logic [11:0] re_num = '0;
  logic [63:0] miso_word;

  logic [11:0] exp_num;
  logic [23:0] exp_val;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_we === 1'b1) begin
      we_cnt++;
      we_cyc = cyc;
    end
    if (frame_err === 1'b1) err_cnt++;
`ifdef SPI_REGISTER_READBACK_EN
    if (reg_re === 1'b1) begin
      re_cnt++;
      re_num = reg_num;
    end
`endif
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit at SCK = clk/8; MISO is sampled just before the rising edge.
  task automatic spi_bit(input logic b, output logic seen);
    mosi = b;
    wait_clks(1);
    seen = miso;
    sck = 1'b1;
    wait_clks(4);
    sck = 1'b0;
    wait_clks(3);
  endtask

  task automatic send_bits(input logic [39:0] f, input int n);
    logic s;
    logic b;
    for (int i = 0; i < n; i++) begin
      if (i < 40) b = f[39-i];
      else b = 1'($urandom_range(0, 1));
      spi_bit(b, s);
      miso_word = {miso_word[62:0], s};
    end
  endtask

  task automatic frame(input string tag, input logic [39:0] f, input int n);
    int   we0, err0, re0;
    logic write_ok, read_ok, read_seen;
    we0 = we_cnt;
    err0 = err_cnt;
    re0 = re_cnt;
    miso_word = '0;
    cs_n = 1'b0;
    wait_clks(4);
    send_bits(f, n);
    cs_n = 1'b1;
    cs_cyc = cyc;
    wait_clks(14);

    write_ok = (n == 40) && (f[39:36] == 4'h1);
    read_ok = 1'b0;
    read_seen = 1'b0;
`ifdef SPI_REGISTER_READBACK_EN
    read_ok = (n == 40) && (f[39:36] == 4'h2);
    read_seen = (n >= 16) && (f[39:36] == 4'h2);
    if (read_seen) exp_num = f[35:24];
`endif
    if (write_ok) begin
      exp_num = f[35:24];
      exp_val = f[23:0];
    end

    check_eq({tag, ".we_pulses"}, 64'(we_cnt - we0), 64'(write_ok));
    check_eq({tag, ".err_pulses"}, 64'(err_cnt - err0), 64'(!(write_ok || read_ok)));
    check_eq({tag, ".reg_num"}, 64'(reg_num), 64'(exp_num));
    check_eq({tag, ".reg_val"}, 64'(reg_val), 64'(exp_val));
    if (write_ok) check_eq({tag, ".latency"}, 64'(we_cyc), 64'(cs_cyc + 5));
    if (read_seen) begin
      check_eq({tag, ".re_pulses"}, 64'(re_cnt - re0), 64'd1);
      check_eq({tag, ".re_num"}, 64'(re_num), 64'(f[35:24]));
      if (read_ok) begin
        check_eq({tag, ".miso_data"}, 64'(miso_word[23:0]), 64'(rd_value));
        check_eq({tag, ".miso_hdr"}, 64'(miso_word[39:24]), 64'd0);
      end
    end
  endtask

  initial begin
    logic [39:0] f;
    int          n;
    int          we0, err0;
    logic [3:0]  cmd;
    logic        s;

    exp_num = '0;
    exp_val = '0;
    miso_word = '0;
    wait_clks(5);
    check_eq("reset.reg_num", 64'(reg_num), 64'd0);
    check_eq("reset.reg_val", 64'(reg_val), 64'd0);
    check_eq("reset.we", 64'(reg_we), 64'd0);
    check_eq("reset.err", 64'(frame_err), 64'd0);
    check_eq("reset.miso", 64'(miso), 64'd0);
    rst = 1'b0;
    wait_clks(8);

    frame("write_basic", 40'h1045ABCDEF, 40);
    frame("short39", 40'h1123456789, 39);
    frame("long41", 40'h1321FEDCBA, 41);
    frame("bad_cmd7", 40'h7123456789, 40);
    frame("write_after_bad", 40'h10C5000001, 40);

    // Reset in the middle of a WRITE, CS_N still low on release.
    we0 = we_cnt;
    err0 = err_cnt;
    cs_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 20; i++) begin
      spi_bit(1'($urandom_range(0, 1)), s);
    end
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    exp_num = '0;
    exp_val = '0;
    wait_clks(6);
    cs_n = 1'b1;
    wait_clks(14);
    check_eq("midreset.we_pulses", 64'(we_cnt - we0), 64'd0);
    check_eq("midreset.err_pulses", 64'(err_cnt - err0), 64'd0);
    check_eq("midreset.reg_num", 64'(reg_num), 64'd0);
    check_eq("midreset.reg_val", 64'(reg_val), 64'd0);
    frame("after_reset", 40'h1ABC123456, 40);

`ifdef SPI_REGISTER_READBACK_EN
    rd_value = 24'h5A5A5A;
    frame("read_basic", 40'h2046000000, 40);
`endif

    for (int k = 0; k < 16; k++) begin
      cmd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h1;
      if (cmd == 4'h2) cmd = 4'h3;
      f = {cmd, 12'($urandom), 24'($urandom)};
      case ($urandom_range(0, 4))
        0: n = 39;
        1: n = 41;
        default: n = 40;
      endcase
      frame($sformatf("rand%0d", k), f, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
